// File: rtl/call_button_conditioner.sv
// call_button_conditioner
//   Conditions raw, asynchronous, bouncy per-floor call buttons into clean
//   one-cycle floor_request pulses and drives the per-floor call lamps.
//   Each floor is handled by an independent call_button_lane instance:
//   2-flop synchroniser -> debounce counter -> rising-edge detect ->
//   duplicate suppression against the lamp -> registered request pulse.
//
// Optional feature (macro STUCK_BUTTON_DETECT_EN):
//   Adds per-floor stuck-button detection. A button held debounced-high for
//   STUCK_CYCLES cycles raises a sticky stuck_fault bit. While the fault is
//   set, that floor can no longer request or light its lamp. With the macro
//   undefined, stuck_fault is tied low.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-low reset
//   btn_raw        raw call buttons (asynchronous, active-high)
//   current_floor  car position
//   door_open      door-open flag; with current_floor, marks a floor served
//   floor_request  one-cycle request pulses
//   call_lamp      pending-call lamps (registered)
//   btn_stable     debounced button levels (registered)
//   stuck_fault    sticky stuck-button flags

module call_button_lane #(
    parameter int DEBOUNCE_CYCLES = 16
`ifdef STUCK_BUTTON_DETECT_EN
    , parameter int STUCK_CYCLES = 1024
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic serve,
    output logic btn_stable,
    output logic floor_request,
    output logic call_lamp,
    output logic stuck_fault
);
    localparam logic [7:0] DB_MAX = 8'(DEBOUNCE_CYCLES);

    logic       s1, s2;
    logic       stable_d;
    logic [7:0] db_cnt;
    logic       acc;
    logic       fault;

    // Pulse for the cycle after btn_stable rises; falls are ignored.
    assign acc = btn_stable & ~stable_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            stable_d      <= 1'b0;
            db_cnt        <= 8'd0;
            btn_stable    <= 1'b0;
            floor_request <= 1'b0;
            call_lamp     <= 1'b0;
        end else begin
            s1       <= btn_raw;
            s2       <= s1;
            stable_d <= btn_stable;

            // Any sample equal to the accepted level restarts the count.
            if (s2 != btn_stable) begin
                if (db_cnt + 8'd1 == DB_MAX) begin
                    btn_stable <= s2;
                    db_cnt     <= 8'd0;
                end else begin
                    db_cnt <= db_cnt + 8'd1;
                end
            end else begin
                db_cnt <= 8'd0;
            end

            // A floor being served right now swallows the new call.
            floor_request <= acc & ~call_lamp & ~serve & ~fault;

            if (serve)
                call_lamp <= 1'b0;
            else if (acc & ~fault)
                call_lamp <= 1'b1;
        end
    end

`ifdef STUCK_BUTTON_DETECT_EN
    localparam int              SW     = $clog2(STUCK_CYCLES) + 1;
    localparam logic [SW-1:0]   ST_MAX = SW'(STUCK_CYCLES);

    logic [SW-1:0] st_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_cnt      <= '0;
            stuck_fault <= 1'b0;
        end else begin
            if (!btn_stable)
                st_cnt <= '0;
            else if (st_cnt != ST_MAX)
                st_cnt <= st_cnt + SW'(1);

            // Sticky until reset; set on the edge the count reaches the limit.
            if (btn_stable && (st_cnt + SW'(1) == ST_MAX))
                stuck_fault <= 1'b1;
        end
    end

    assign fault = stuck_fault;
`else
    assign stuck_fault = 1'b0;
    assign fault       = 1'b0;
`endif

endmodule

module call_button_conditioner #(
    parameter int NUM_FLOORS      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FLOOR_W         = 2,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn_raw,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    output logic [NUM_FLOORS-1:0] floor_request,
    output logic [NUM_FLOORS-1:0] call_lamp,
    output logic [NUM_FLOORS-1:0] btn_stable,
    output logic [NUM_FLOORS-1:0] stuck_fault
);
    // Elaboration-time parameter sanity.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
        $error("DEBOUNCE_CYCLES must be in 2..255");
    end
    if (FLOOR_W != $clog2(NUM_FLOORS)) begin : g_bad_fw
        $error("FLOOR_W must equal clog2(NUM_FLOORS)");
    end
    if (STUCK_CYCLES < 2) begin : g_bad_st
        $error("STUCK_CYCLES must be at least 2");
    end

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_lane
        logic serve;

        // Only in-range floor codes can match; out-of-range codes serve nothing.
        assign serve = door_open && (current_floor == FLOOR_W'(i));

        call_button_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef STUCK_BUTTON_DETECT_EN
            , .STUCK_CYCLES  (STUCK_CYCLES)
`endif
        ) u_lane (
            .clk           (clk),
            .reset         (reset),
            .btn_raw       (btn_raw[i]),
            .serve         (serve),
            .btn_stable    (btn_stable[i]),
            .floor_request (floor_request[i]),
            .call_lamp     (call_lamp[i]),
            .stuck_fault   (stuck_fault[i])
        );
    end

endmodule

// File: tb/tb_call_button_conditioner.sv
// Bench for call_button_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=32.
// A behavioural model (sample history window + pending-call bookkeeping) is
// compared against the DUT on every cycle; directed literal checks at known
// edge numbers pin the model to the hand-derived timing.
module tb_call_button_conditioner;
    localparam int NF = 4;
    localparam int FW = 2;
    localparam int D  = 4;
    localparam int SC = 32;
`ifdef STUCK_BUTTON_DETECT_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] btn_raw;
    logic [FW-1:0] current_floor;
    logic          door_open;
    logic [NF-1:0] floor_request, call_lamp, btn_stable, stuck_fault;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;   // number of rising edges so far

    call_button_conditioner #(
        .NUM_FLOORS(NF), .DEBOUNCE_CYCLES(D), .FLOOR_W(FW), .STUCK_CYCLES(SC)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .current_floor(current_floor), .door_open(door_open),
        .floor_request(floor_request), .call_lamp(call_lamp),
        .btn_stable(btn_stable), .stuck_fault(stuck_fault)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Per floor: raw samples pass a 2-deep delay; the accepted level flips once
    // the most recent D delayed samples all disagree with it.
    bit          p0 [NF], p1 [NF];
    logic [31:0] hist [NF];
    int          hv [NF];
    bit          st [NF], rose [NF], m_req [NF], m_lamp [NF], m_flt [NF];
    int          run [NF];
    localparam logic [31:0] MASK = (32'd1 << D) - 32'd1;

    always @(posedge clk) begin
        cyc++;
        for (int f = 0; f < NF; f++) begin
            if (!reset) begin
                p0[f] = 0; p1[f] = 0; hist[f] = '0; hv[f] = 0;
                st[f] = 0; rose[f] = 0; m_req[f] = 0; m_lamp[f] = 0;
                m_flt[f] = 0; run[f] = 0;
            end else begin
                bit serve;
                serve    = door_open && (current_floor == FW'(f));
                m_req[f] = rose[f] && !m_lamp[f] && !serve && !m_flt[f];
                if (serve)         m_lamp[f] = 0;
                else if (m_req[f]) m_lamp[f] = 1;
                else if (rose[f] && !m_flt[f]) m_lamp[f] = 1;
                if (STUCK_EN) begin
                    run[f] = st[f] ? run[f] + 1 : 0;
                    if (run[f] >= SC) m_flt[f] = 1;
                end
                hist[f] = {hist[f][30:0], p1[f]};
                if (hv[f] < 32) hv[f]++;
                rose[f] = 0;
                if (hv[f] >= D && ((hist[f] ^ {32{~st[f]}}) & MASK) == 32'd0) begin
                    st[f]   = ~st[f];
                    rose[f] = st[f];
                    hv[f]   = 0;
                end
                p1[f] = p0[f];
                p0[f] = btn_raw[f];
            end
        end
    end

    function automatic logic [NF-1:0] pack(input bit v [NF]);
        logic [NF-1:0] r;
        for (int f = 0; f < NF; f++) r[f] = v[f];
        return r;
    endfunction

    task automatic chk(input string name, input logic [NF-1:0] act, input logic [NF-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Per-cycle model comparison, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("model btn_stable",    btn_stable,    pack(st));
            chk("model floor_request", floor_request, pack(m_req));
            chk("model call_lamp",     call_lamp,     pack(m_lamp));
            chk("model stuck_fault",   stuck_fault,   pack(m_flt));
        end
    end

    // Advance to the negedge right after rising edge n.
    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b0; btn_raw = '0; current_floor = '0; door_open = 1'b0;

        // Reset / latency
        wait_to(3);
        chk("reset req",    floor_request, 4'b0000);
        chk("reset lamp",   call_lamp,     4'b0000);
        chk("reset stable", btn_stable,    4'b0000);
        chk("reset fault",  stuck_fault,   4'b0000);
        reset = 1'b1;
        wait_to(9);  btn_raw[2] = 1'b1;            // first sampled at edge 10
        wait_to(14); chk("lat stable@14", btn_stable, 4'b0000);
        wait_to(15); chk("lat stable@15", btn_stable, 4'b0100);
                     chk("lat req@15",    floor_request, 4'b0000);
        wait_to(16); chk("lat req@16",    floor_request, 4'b0100);
                     chk("lat lamp@16",   call_lamp,     4'b0100);
        wait_to(17); chk("lat req@17",    floor_request, 4'b0000);
                     btn_raw[2] = 1'b0;
        wait_to(24); current_floor = 2'd2; door_open = 1'b1;
        wait_to(25); door_open = 1'b0;
                     chk("serve2 lamp", call_lamp, 4'b0000);

        // Bounce rejection on floor 1: samples at edges 31..36 = 1,1,0,1,1,0
        wait_to(30); btn_raw[1] = 1'b1;
        wait_to(31); btn_raw[1] = 1'b1;
        wait_to(32); btn_raw[1] = 1'b0;
        wait_to(33); btn_raw[1] = 1'b1;
        wait_to(34); btn_raw[1] = 1'b1;
        wait_to(35); btn_raw[1] = 1'b0;
        wait_to(36); btn_raw[1] = 1'b1;            // held from edge 37
        wait_to(41); chk("bounce stable@41", btn_stable,    4'b0000);
        wait_to(42); chk("bounce req@42",    floor_request, 4'b0000);
        wait_to(43); chk("bounce req@43",    floor_request, 4'b0010);
        wait_to(44); chk("bounce req@44",    floor_request, 4'b0000);
                     btn_raw[1] = 1'b0;
        wait_to(50); current_floor = 2'd1; door_open = 1'b1;
        wait_to(51); door_open = 1'b0;
                     chk("serve1 lamp", call_lamp, 4'b0000);

        // Duplicate suppression / service on floor 3
        wait_to(52); btn_raw[3] = 1'b1;
        wait_to(59); chk("dup first req", floor_request, 4'b1000);
        wait_to(60); btn_raw[3] = 1'b0;
        wait_to(68); btn_raw[3] = 1'b1;
        wait_to(74); chk("dup stable@74", btn_stable, 4'b1000);
        wait_to(75); chk("dup req@75",    floor_request, 4'b0000);
                     chk("dup lamp@75",   call_lamp,     4'b1000);
        wait_to(76); btn_raw[3] = 1'b0;
        wait_to(84); current_floor = 2'd3; door_open = 1'b1;
        wait_to(85); door_open = 1'b0;
                     chk("serve3 lamp", call_lamp, 4'b0000);
        wait_to(86); btn_raw[3] = 1'b1;
        wait_to(93); chk("repress req@93", floor_request, 4'b1000);
        wait_to(94); btn_raw[3] = 1'b0;

        // Collision: door open at floor 0 while floor 0 is pressed
        wait_to(100); current_floor = 2'd0; door_open = 1'b1; btn_raw[0] = 1'b1;
        wait_to(106); chk("coll stable@106", btn_stable, 4'b0001);
        wait_to(107); chk("coll req@107",    floor_request, 4'b0000);
                      chk("coll lamp@107",   call_lamp,     4'b1000);
        wait_to(108); btn_raw[0] = 1'b0;
        wait_to(110); btn_raw[2:1] = 2'b11;
        wait_to(117); chk("multi req@117", floor_request, 4'b0110);
        wait_to(118); btn_raw[2:1] = 2'b00; door_open = 1'b0;

        // Reset in the middle of a debounce on floor 0
        wait_to(126); btn_raw[0] = 1'b1;           // first sampled at 127
        wait_to(130); reset = 1'b0;                // edges 131,132
        wait_to(132); chk("midrst all", {btn_stable, call_lamp}, 8'h00);
                      reset = 1'b1;                // first post-reset sample 133
        wait_to(137); chk("midrst stable@137", btn_stable,    4'b0000);
        wait_to(138); chk("midrst stable@138", btn_stable,    4'b0001);
        wait_to(139); chk("midrst req@139",    floor_request, 4'b0001);
        wait_to(140); chk("midrst req@140",    floor_request, 4'b0000);
                      btn_raw[0] = 1'b0;

`ifdef STUCK_BUTTON_DETECT_EN
        wait_to(142); btn_raw[1] = 1'b1;           // stable 148, pulse 149
        wait_to(149); chk("stuck first req", floor_request, 4'b0010);
        wait_to(179); chk("stuck fault@179", stuck_fault, 4'b0000);
        wait_to(180); chk("stuck fault@180", stuck_fault, 4'b0010);
        wait_to(181); current_floor = 2'd1; door_open = 1'b1;
        wait_to(182); door_open = 1'b0; btn_raw[1] = 1'b0;
        wait_to(190); btn_raw[1] = 1'b1;
        wait_to(197); chk("stuck req@197",   floor_request, 4'b0000);
                      chk("stuck lamp@197",  call_lamp,     4'b0000);
                      chk("stuck fault@197", stuck_fault,   4'b0010);
`endif

        wait_to(cyc + 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
